coin_acceptor: RTL and testbench

- Front end for the vending dispenser: turns raw, bouncing coin-slot switches into clean single-cycle coin events `u` (1-unit coin) and `d` (2-unit coin).
- Provides synchronisation, per-channel debounce, post-coin lockout, simultaneous-coin rejection and a saturating reject counter.
- Sits between the coin-slot pins and the dispenser FSM, in the same clock domain (`clk`).

---
 rtl/coin_acceptor.sv | 114 +++++++++++
 tb/tb_coin_acceptor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces two raw coin switches and
// emits single-cycle u/d events, with post-coin lockout and reject counting.
module coin_acceptor #(
    parameter int DEB_CYCLES     = 500000,
    parameter int LOCKOUT_CYCLES = 2500000,
    parameter int CNT_W          = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin1_raw,
    input  logic       coin2_raw,
    output logic       u,
    output logic       d,
    output logic       busy,
    output logic [3:0] reject_cnt
);
    // state        | meaning
    // IDLE         | waiting for a debounced rise on either channel
    // LOCKOUT      | coin accepted, all rises ignored for LOCKOUT_CYCLES
    // WAIT_RELEASE | waiting for both debounced levels to return low
    typedef enum logic [1:0] {IDLE, LOCKOUT, WAIT_RELEASE} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    state_t           state;
    logic [1:0]       meta;
    logic [1:0]       sync;
    logic [1:0]       deb;
    logic [1:0]       deb_q;
    logic [1:0]       rise;
    logic [CNT_W-1:0] dcnt [2];
    logic [CNT_W-1:0] lcnt;

    assign rise = deb & ~deb_q;

    // Per-channel debounce: any sample matching the current level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= '0;
            sync    <= '0;
            deb     <= '0;
            deb_q   <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            meta  <= {coin2_raw, coin1_raw};
            sync  <= meta;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    deb[i]  <= ~deb[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lcnt       <= '0;
            u          <= 1'b0;
            d          <= 1'b0;
            busy       <= 1'b0;
            reject_cnt <= '0;
        end else begin
            u <= 1'b0;
            d <= 1'b0;
            case (state)
                IDLE: begin
                    lcnt <= '0;
                    if (rise[0] && !deb[1]) begin
                        u     <= 1'b1;
                        busy  <= 1'b1;
                        state <= LOCKOUT;
                    end else if (rise[1] && !deb[0]) begin
                        d     <= 1'b1;
                        busy  <= 1'b1;
                        state <= LOCKOUT;
                    end else if (rise != 2'b00) begin
                        // Simultaneous coins, or a rise while the other slot is held.
                        if (reject_cnt != 4'hF)
                            reject_cnt <= reject_cnt + 4'd1;
                        busy  <= 1'b1;
                        state <= WAIT_RELEASE;
                    end
                end
                LOCKOUT: begin
                    if (lcnt == LOCK_LAST) begin
                        lcnt  <= '0;
                        state <= WAIT_RELEASE;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    if (deb == 2'b00) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEB_CYCLES=4, LOCKOUT_CYCLES=8, CNT_W=4.
module tb_coin_acceptor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin1_raw = 1'b0;
    logic       coin2_raw = 1'b0;
    logic       u, d, busy;
    logic [3:0] reject_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    coin_acceptor #(.DEB_CYCLES(4), .LOCKOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .coin1_raw(coin1_raw), .coin2_raw(coin2_raw),
        .u(u), .d(d), .busy(busy), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    // Inputs held for n cycles; outputs expected constant over each of those cycles.
    typedef struct {
        logic       c1;
        logic       c2;
        int         n;
        logic       eu;
        logic       ed;
        logic       eb;
        logic [3:0] er;
    } vec_t;

    vec_t tbl [64];
    int   n_tbl = 0;

    task automatic add(input logic c1, input logic c2, input int n, input logic eu,
                       input logic ed, input logic eb, input logic [3:0] er);
        tbl[n_tbl] = '{c1, c2, n, eu, ed, eb, er};
        n_tbl++;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic step(input logic c1, input logic c2);
        @(negedge clk);
        coin1_raw = c1;
        coin2_raw = c2;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic eu, input logic ed,
                              input logic eb, input logic [3:0] er);
        chk({tag, ".u"}, {3'b0, u}, {3'b0, eu});
        chk({tag, ".d"}, {3'b0, d}, {3'b0, ed});
        chk({tag, ".busy"}, {3'b0, busy}, {3'b0, eb});
        chk({tag, ".reject_cnt"}, reject_cnt, er);
    endtask

    task automatic run_table(input int first, input int last);
        for (int i = first; i <= last; i++)
            for (int c = 0; c < tbl[i].n; c++) begin
                step(tbl[i].c1, tbl[i].c2);
                check_outs($sformatf("vec%0d.%0d", i, c), tbl[i].eu, tbl[i].ed, tbl[i].eb, tbl[i].er);
            end
    endtask

    initial begin
        logic [3:0] exp_rc;
        logic       seen;

        // clean coin1: u on the 7th edge, lockout, release
        add(1,0,6, 0,0,0,0); add(1,0,1, 1,0,1,0); add(1,0,13, 0,0,1,0);
        add(0,0,6, 0,0,1,0); add(0,0,5, 0,0,0,0);
        // bouncing coin2, stable run starts at the 5th record
        add(0,1,1, 0,0,0,0); add(0,0,1, 0,0,0,0); add(0,1,2, 0,0,0,0); add(0,0,1, 0,0,0,0);
        add(0,1,6, 0,0,0,0); add(0,1,1, 0,1,1,0); add(0,1,3, 0,0,1,0);
        add(0,0,6, 0,0,1,0); add(0,0,4, 0,0,0,0);
        // short coin1 glitch is filtered
        add(1,0,3, 0,0,0,0); add(0,0,10, 0,0,0,0);
        // simultaneous coins: reject
        add(1,1,6, 0,0,0,0); add(1,1,4, 0,0,1,1); add(0,0,6, 0,0,1,1); add(0,0,4, 0,0,0,1);
        // second coin rises during lockout and is held: ignored
        add(1,0,6, 0,0,0,1); add(1,0,1, 1,0,1,1); add(1,0,1, 0,0,1,1); add(1,1,4, 0,0,1,1);
        add(0,1,16, 0,0,1,1); add(0,0,6, 0,0,1,1); add(0,0,3, 0,0,0,1);
        // new coin1 accepted again
        add(1,0,6, 0,0,0,1); add(1,0,1, 1,0,1,1); add(1,0,8, 0,0,1,1);
        add(0,0,6, 0,0,1,1); add(0,0,3, 0,0,0,1);

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_table(0, n_tbl - 1);

        // 16 more simultaneous rejects saturate the counter
        exp_rc = 4'd1;
        for (int k = 0; k < 16; k++) begin
            repeat (7) step(1, 1);
            repeat (10) step(0, 0);
            exp_rc = (exp_rc == 4'hF) ? 4'hF : exp_rc + 4'd1;
            chk($sformatf("sat%0d.reject_cnt", k), reject_cnt, exp_rc);
        end
        chk("sat.busy", {3'b0, busy}, 4'd0);

        // reset in the middle of lockout
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step(1, 0);
            seen = u;
        end
        chk("rst_mid.u_seen", {3'b0, seen}, 4'd1);
        repeat (3) step(1, 0);
        chk("rst_mid.busy_before", {3'b0, busy}, 4'd1);
        rst_n = 1'b0;
        coin1_raw = 1'b0;
        #1;
        check_outs("rst_mid.async", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_outs("rst_mid.held", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(0, 0);
            check_outs($sformatf("post_rst%0d", c), 0, 0, 0, 0);
        end
        run_table(0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
